count_checker: RTL and testbench
================================

# count_checker

Downstream consumer of the 8-bit free-running counter stage. It samples each count value the counter produces and checks that consecutive samples advance by exactly +1 modulo 2^WIDTH. It counts discontinuities and queues each one as an (expected, actual) event in a small FIFO that the bench or a status block drains over a valid/ready handshake.

## Interface
- WIDTH, 8: width of the checked count value.
- ERR_WIDTH, 8: width of the saturating error counter.
- DEPTH, 4: event FIFO entries; must be a power of two and at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low; asserting it forces every register to its reset value immediately.
- in_valid  in  1  in_count holds a sample this cycle.
- in_count  in  WIDTH  sampled counter value.
- in_clear  in  1  synchronous clear of the checker state.
- locked  out  1  checker has a reference value.
- err_count  out  ERR_WIDTH  number of mismatches, saturating.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.
- ev_valid  out  1  FIFO is non-empty.
- ev_ready  in  1  consumer accepts the head event.
- ev_expected  out  WIDTH  head event: the expected value.
- ev_actual  out  WIDTH  head event: the received value.

## Operation
- States:
  - UNLOCKED (reset state).
  - LOCKED.
  - `locked` = (state == LOCKED).
- Register `exp` (WIDTH bits) holds the next expected value. Its reset value is 0.
- UNLOCKED with in_valid:
  - exp <= in_count + 1, truncated to WIDTH.
  - Go to LOCKED.
  - No check, no error.
- LOCKED with in_valid:
  - Match (in_count == exp): exp <= exp + 1, wrapping, so 0xFF → 0x00 is a match when WIDTH=8.
  - Restart (in_count == 0 and in_count != exp): a legitimate upstream reset. exp <= 1. No error, no event.
  - Mismatch (any other value): err_count += 1, saturating at all-ones. Push {exp, in_count} into the FIFO. Resync with exp <= in_count + 1. Stay LOCKED.
- in_valid low: no state change.
- in_clear high:
  - state <= UNLOCKED, exp <= 0, err_count <= 0, overflow <= 0.
  - FIFO is flushed.
  - Clear wins over a simultaneous in_valid (the sample is discarded) and over a simultaneous pop.
- FIFO:
  - Pop happens when ev_valid && ev_ready.
  - Push when full:
    - With a pop in the same cycle, the push is accepted.
    - Otherwise the event is dropped, overflow <= 1, and err_count still increments.
  - Push into an empty FIFO with ev_ready high: the entry is written and becomes visible next cycle. There is no fall-through.
  - ev_expected/ev_actual reflect the head entry. They are 0 while the FIFO is empty after reset or clear.
  - Occupancy uses read/write pointers of log2(DEPTH)+1 bits. Full and empty are derived from the MSB comparison.

## Timing
- Reset values:
  - locked=0, err_count=0, overflow=0.
  - ev_valid=0, ev_expected=0, ev_actual=0.
  - Internal: exp=0, pointers=0.
- A sample is consumed at the rising edge where in_valid=1.
- A mismatch sampled at edge N produces:
  - err_count updated after edge N.
  - ev_valid=1 after edge N, if the FIFO was empty.
  - This is 1-cycle latency.
- locked rises after the first accepted sample edge.
- ev_valid is a registered occupancy flag. It does not depend combinationally on ev_ready.
- ev_expected/ev_actual are stable while ev_valid=1 && ev_ready=0.
- rst asserted mid-stream clears everything asynchronously. The first sample after release only locks.

## Test plan
1. Reset, then feed 0x00..0x10, one per cycle → locked=1 after the first edge, err_count=0, ev_valid never asserts.
2. Locked at exp=0xFE, feed 0xFE, 0xFF, 0x00, 0x01 → no errors (wrap-around accepted).
3. Feed 5, 6, 9, 10 with ev_ready=0 → err_count=1, one event {expected=7, actual=9}, ev_valid=1 one cycle after the 9 sample. The later 10 is a match.
4. Feed 20, 21, 0, 1, 2 → restart path: err_count=0, no event.
5. ev_ready=0, inject 5 mismatches with DEPTH=4 → FIFO holds the first 4 events in order, overflow=1, err_count=5. Then drain with ev_ready=1 → 4 pops, ev_valid drops.
6. Assert in_clear together with a mismatching in_valid → err_count=0, locked=0, FIFO empty, overflow=0. Separately, assert rst mid-stream → all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/count_checker.sv
`default_nettype none
// ============================================================================
// Module   : count_checker
// Purpose  : Watches the sample stream from the upstream free-running
//            counter and checks that each sample is the previous one plus
//            one, modulo 2^WIDTH. A return to zero is treated as an upstream
//            restart, not an error. Every other discontinuity increments a
//            saturating error counter and queues an (expected, actual) event
//            in a small FIFO that is drained over a valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH       width of the checked count value
//   ERR_WIDTH   width of the saturating error counter
//   DEPTH       event FIFO entries (power of two, >= 2)
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   in_valid     in   in_count holds a sample this cycle
//   in_count     in   sampled counter value
//   in_clear     in   synchronous clear of checker state and FIFO
//   locked       out  checker holds a reference value
//   err_count    out  saturating mismatch count
//   overflow     out  sticky: an event was dropped on a full FIFO
//   ev_valid     out  event FIFO non-empty
//   ev_ready     in   consumer accepts the head event
//   ev_expected  out  head event expected value
//   ev_actual    out  head event received value
// ============================================================================
module count_checker #(
  parameter int WIDTH     = 8,
  parameter int ERR_WIDTH = 8,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_count,
  input  logic                 in_clear,
  output logic                 locked,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic                 overflow,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [WIDTH-1:0]     ev_expected,
  output logic [WIDTH-1:0]     ev_actual
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_exp;
  logic [ERR_WIDTH-1:0] r_err;
  logic                 r_ovf;
  logic [AW:0]          r_wptr;
  logic [AW:0]          r_rptr;
  logic [WIDTH-1:0]     r_mem_exp [DEPTH];
  logic [WIDTH-1:0]     r_mem_act [DEPTH];

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_match;
  logic             w_restart;
  logic             w_push;
  logic             w_push_ok;
  logic [WIDTH-1:0] w_inc;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index bits with differing wrap bits mean full.
  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop     = !w_empty && ev_ready;
  assign w_inc     = in_count + 1'b1;
  assign w_match   = (in_count == r_exp);
  assign w_restart = (in_count == '0) && !w_match;
  assign w_push    = in_valid && (r_state == LOCKED) && !w_match && !w_restart;
  // A pop in the same cycle frees the slot the push needs.
  assign w_push_ok = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= UNLOCKED;
      r_exp   <= '0;
      r_err   <= '0;
      r_ovf   <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_exp[i] <= '0;
        r_mem_act[i] <= '0;
      end
    end else if (in_clear) begin
      // Clear beats any simultaneous sample or pop. Stale FIFO contents
      // are hidden by the output gating below.
      r_state <= UNLOCKED;
      r_exp   <= '0;
      r_err   <= '0;
      r_ovf   <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (in_valid) begin
        case (r_state)
          UNLOCKED: begin
            r_exp   <= w_inc;
            r_state <= LOCKED;
          end
          LOCKED: begin
            if (w_match) begin
              r_exp <= r_exp + 1'b1;
            end else if (w_restart) begin
              r_exp <= WIDTH'(1);
            end else begin
              if (r_err != '1) begin
                r_err <= r_err + 1'b1;
              end
              r_exp <= w_inc;
              if (w_push_ok) begin
                r_mem_exp[r_wptr[AW-1:0]] <= r_exp;
                r_mem_act[r_wptr[AW-1:0]] <= in_count;
                r_wptr                    <= r_wptr + 1'b1;
              end else begin
                r_ovf <= 1'b1;
              end
            end
          end
          default: r_state <= UNLOCKED;
        endcase
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  assign locked      = (r_state == LOCKED);
  assign err_count   = r_err;
  assign overflow    = r_ovf;
  assign ev_valid    = !w_empty;
  // Head data reads as zero whenever the FIFO is empty.
  assign ev_expected = w_empty ? '0 : r_mem_exp[r_rptr[AW-1:0]];
  assign ev_actual   = w_empty ? '0 : r_mem_act[r_rptr[AW-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_count_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_checker
// Purpose  : Directed self-checking bench for count_checker with
//            hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_checker;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_count;
  logic       in_clear;
  logic       locked;
  logic [7:0] err_count;
  logic       overflow;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_expected;
  logic [7:0] ev_actual;

  int n_cmp;
  int n_bad;

  count_checker #(.WIDTH(8), .ERR_WIDTH(8), .DEPTH(4)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_count    (in_count),
    .in_clear    (in_clear),
    .locked      (locked),
    .err_count   (err_count),
    .overflow    (overflow),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_expected (ev_expected),
    .ev_actual   (ev_actual)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked at
  // the same point, well away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [7:0] v);
    in_valid = 1'b1;
    in_count = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    in_clear = 1'b1;
    tick();
    in_clear = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_locked"},   locked,      0);
    check_eq({tag, "_err"},      err_count,   0);
    check_eq({tag, "_ovf"},      overflow,    0);
    check_eq({tag, "_ev_valid"}, ev_valid,    0);
    check_eq({tag, "_ev_exp"},   ev_expected, 0);
    check_eq({tag, "_ev_act"},   ev_actual,   0);
  endtask

  logic [7:0] t5_in  [5];
  logic [7:0] t5_exp [4];

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_count = '0;
    in_clear = 1'b0;
    ev_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check_idle("reset");
    rst = 1'b1;
    tick();

    // 1: clean ascending stream 0x00..0x10
    in_valid = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      in_count = 8'(i);
      tick();
      if (i == 0) check_eq("t1_locked_first", locked, 1);
      check_eq("t1_no_event", ev_valid, 0);
    end
    in_valid = 1'b0;
    check_eq("t1_err", err_count, 0);

    // 2: wrap-around FE, FF, 00, 01 is accepted
    do_clear();
    sample(8'hFD);
    sample(8'hFE);
    sample(8'hFF);
    sample(8'h00);
    sample(8'h01);
    check_eq("t2_err",      err_count, 0);
    check_eq("t2_ev_valid", ev_valid,  0);
    check_eq("t2_locked",   locked,    1);

    // 3: 5, 6, 9, 10 -> one event {7, 9}
    do_clear();
    sample(8'd5);
    sample(8'd6);
    check_eq("t3_pre_ev_valid", ev_valid, 0);
    sample(8'd9);
    check_eq("t3_ev_valid",  ev_valid,    1);
    check_eq("t3_err",       err_count,   1);
    check_eq("t3_ev_exp",    ev_expected, 7);
    check_eq("t3_ev_act",    ev_actual,   9);
    sample(8'd10);
    check_eq("t3_err_after", err_count,   1);
    check_eq("t3_ev_hold",   ev_actual,   9);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    check_eq("t3_drained",   ev_valid,    0);

    // 4: restart path 20, 21, 0, 1, 2
    do_clear();
    sample(8'd20);
    sample(8'd21);
    sample(8'd0);
    sample(8'd1);
    sample(8'd2);
    check_eq("t4_err",      err_count, 0);
    check_eq("t4_ev_valid", ev_valid,  0);

    // 5: five mismatches into a 4-deep FIFO, then drain
    do_clear();
    sample(8'd0);                  // lock, next expected 1
    t5_in  = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
    t5_exp = '{8'd1, 8'd11, 8'd21, 8'd31};
    for (int i = 0; i < 5; i++) sample(t5_in[i]);
    check_eq("t5_err",      err_count, 5);
    check_eq("t5_ovf",      overflow,  1);
    check_eq("t5_ev_valid", ev_valid,  1);
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t5_pop%0d_exp", i), ev_expected, t5_exp[i]);
      check_eq($sformatf("t5_pop%0d_act", i), ev_actual,   t5_in[i]);
      tick();
    end
    ev_ready = 1'b0;
    check_eq("t5_empty",     ev_valid, 0);
    check_eq("t5_ovf_stick", overflow, 1);

    // 6a: clear wins over a simultaneous mismatching sample
    do_clear();
    sample(8'd3);                  // expect 4 next
    sample(8'd50);                 // mismatch -> event queued
    check_eq("t6_pre_err", err_count, 1);
    in_clear = 1'b1;
    in_valid = 1'b1;
    in_count = 8'd99;
    ev_ready = 1'b1;
    tick();
    in_clear = 1'b0;
    in_valid = 1'b0;
    ev_ready = 1'b0;
    check_idle("t6_clear");
    sample(8'd7);
    check_eq("t6_relock",     locked,    1);
    check_eq("t6_relock_err", err_count, 0);

    // 6b: asynchronous reset mid-stream
    sample(8'd50);                 // expected 8 -> mismatch
    check_eq("t6_pre_rst_ev", ev_valid, 1);
    #2;
    rst = 1'b0;                    // between clock edges
    #1;
    check_idle("t6_async_rst");
    #3;
    rst = 1'b1;
    tick();
    sample(8'd60);
    check_eq("t6_rst_lock",     locked,    1);
    check_eq("t6_rst_lock_err", err_count, 0);
    check_eq("t6_rst_lock_ev",  ev_valid,  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
